// File: rtl/mover_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mover_pkg                                                        |
// | Shared opcodes, motion types and default geometry constants.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mover_pkg;

    localparam int C_N_OBJ    = 4;
    localparam int C_SCREEN_W = 640;
    localparam int C_SCREEN_H = 480;
    localparam int C_OBJ_W    = 32;
    localparam int C_OBJ_H    = 24;
    localparam int C_STEP     = 5;
    localparam int C_CW       = 11;

    typedef enum logic [2:0] {
        OP_STOP   = 3'd0,
        OP_LEFT   = 3'd1,
        OP_RIGHT  = 3'd2,
        OP_UP     = 3'd3,
        OP_DOWN   = 3'd4,
        OP_CENTER = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } mover_op_e;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } mover_dir_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } mover_state_e;

endpackage
`default_nettype wire

// File: rtl/object_motion.sv
`default_nettype none
// +------------------------------------------------------------------+
// | object_motion                                                    |
// | One object's IDLE/MOVING FSM, step counter and position update.  |
// | OBJ_WRAP_EN selects wrap-around instead of clamping at the edges.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module object_motion
    import mover_pkg::*;
#(
    parameter int SCREEN_W = C_SCREEN_W,
    parameter int SCREEN_H = C_SCREEN_H,
    parameter int OBJ_W    = C_OBJ_W,
    parameter int OBJ_H    = C_OBJ_H,
    parameter int STEP     = C_STEP,
    parameter int CW       = C_CW
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_frame_tick,
    input  logic          i_cmd_en,
    input  logic [2:0]    i_cmd_op,
    input  logic [7:0]    i_cmd_count,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_busy,
    output logic          o_hit_edge
);

    localparam logic [CW-1:0]        C_CX     = CW'((SCREEN_W - OBJ_W) / 2);
    localparam logic [CW-1:0]        C_CY     = CW'((SCREEN_H - OBJ_H) / 2);
    localparam logic signed [CW:0]   C_STEP_S = (CW+1)'(STEP);
    localparam logic signed [CW:0]   C_MAX_X  = (CW+1)'(SCREEN_W - OBJ_W);
    localparam logic signed [CW:0]   C_MAX_Y  = (CW+1)'(SCREEN_H - OBJ_H);
`ifdef OBJ_WRAP_EN
    localparam logic signed [CW:0]   C_SPAN_X = (CW+1)'(SCREEN_W - OBJ_W + 1);
    localparam logic signed [CW:0]   C_SPAN_Y = (CW+1)'(SCREEN_H - OBJ_H + 1);
    logic signed [CW:0] w_span;
`endif

    mover_state_e  r_state, w_state_nxt;
    mover_dir_e    r_dir, w_dir_nxt;
    logic [7:0]    r_cnt, w_cnt_nxt;
    logic [CW-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic          r_hit, w_hit_nxt;

    logic               w_horiz, w_neg, w_edge, w_last;
    logic signed [CW:0] w_pos, w_raw, w_max;
    logic [CW-1:0]      w_res;
    mover_op_e          w_op;

    assign w_op    = mover_op_e'(i_cmd_op);
    assign w_horiz = (r_dir == DIR_LEFT) || (r_dir == DIR_RIGHT);
    assign w_neg   = (r_dir == DIR_LEFT) || (r_dir == DIR_UP);
    assign w_pos   = w_horiz ? $signed({1'b0, r_x}) : $signed({1'b0, r_y});
    assign w_max   = w_horiz ? C_MAX_X : C_MAX_Y;
    assign w_raw   = w_neg ? (w_pos - C_STEP_S) : (w_pos + C_STEP_S);

    // Candidate coordinate for a step; landing exactly on a bound is not an edge event.
    always_comb begin
        w_res  = w_raw[CW-1:0];
        w_edge = 1'b0;
        w_last = (r_cnt == 8'd1);
`ifdef OBJ_WRAP_EN
        w_span = w_horiz ? C_SPAN_X : C_SPAN_Y;
        if (w_raw[CW]) begin
            w_res  = CW'(w_raw + w_span);
            w_edge = 1'b1;
        end else if (w_raw > w_max) begin
            w_res  = CW'(w_raw - w_span);
            w_edge = 1'b1;
        end
`else
        if (w_raw[CW]) begin
            w_res  = '0;
            w_edge = 1'b1;
            w_last = 1'b1;
        end else if (w_raw > w_max) begin
            w_res  = w_max[CW-1:0];
            w_edge = 1'b1;
            w_last = 1'b1;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_hit_nxt   = 1'b0;
        if (i_cmd_en) begin
            case (w_op)
                OP_STOP: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
                OP_CENTER: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_x_nxt     = C_CX;
                    w_y_nxt     = C_CY;
                end
                OP_LEFT, OP_RIGHT, OP_UP, OP_DOWN: begin
                    if (i_cmd_count != 8'd0) begin
                        w_state_nxt = ST_MOVING;
                        w_cnt_nxt   = i_cmd_count;
                        case (w_op)
                            OP_LEFT:  w_dir_nxt = DIR_LEFT;
                            OP_RIGHT: w_dir_nxt = DIR_RIGHT;
                            OP_UP:    w_dir_nxt = DIR_UP;
                            default:  w_dir_nxt = DIR_DOWN;
                        endcase
                    end
                end
                default: ;
            endcase
        end else if (i_frame_tick && (r_state == ST_MOVING)) begin
            if (w_horiz) w_x_nxt = w_res;
            else         w_y_nxt = w_res;
            w_hit_nxt = w_edge;
            w_cnt_nxt = w_last ? 8'd0 : (r_cnt - 8'd1);
            if (w_last) w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_LEFT;
            r_cnt   <= '0;
            r_x     <= C_CX;
            r_y     <= C_CY;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_hit   <= w_hit_nxt;
        end
    end

    assign o_x        = r_x;
    assign o_y        = r_y;
    assign o_busy     = (r_state == ST_MOVING);
    assign o_hit_edge = r_hit;

endmodule
`default_nettype wire

// File: rtl/multi_object_mover.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multi_object_mover                                               |
// | Command decode and N_OBJ independent object_motion instances.    |
// | OBJ_WRAP_EN selects wrap-around instead of clamping at the edges.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module multi_object_mover
    import mover_pkg::*;
#(
    parameter int N_OBJ    = C_N_OBJ,
    parameter int SCREEN_W = C_SCREEN_W,
    parameter int SCREEN_H = C_SCREEN_H,
    parameter int OBJ_W    = C_OBJ_W,
    parameter int OBJ_H    = C_OBJ_H,
    parameter int STEP     = C_STEP,
    parameter int CW       = C_CW,
    localparam int C_IDW   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [C_IDW-1:0]   cmd_id,
    input  logic [2:0]         cmd_op,
    input  logic [7:0]         cmd_count,
    output logic [N_OBJ*CW-1:0] obj_x,
    output logic [N_OBJ*CW-1:0] obj_y,
    output logic [N_OBJ-1:0]   busy,
    output logic [N_OBJ-1:0]   hit_edge
);

    logic w_target_busy;
    logic w_accept;

    // Out-of-range ids match no object and therefore read as not busy.
    always_comb begin
        w_target_busy = 1'b0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (cmd_id == C_IDW'(i)) w_target_busy = busy[i];
        end
    end

    assign cmd_ready = (cmd_op == OP_STOP) || (cmd_op == OP_CENTER) || !w_target_busy;
    assign w_accept  = cmd_valid && cmd_ready;

    generate
        for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_obj
            object_motion #(
                .SCREEN_W (SCREEN_W),
                .SCREEN_H (SCREEN_H),
                .OBJ_W    (OBJ_W),
                .OBJ_H    (OBJ_H),
                .STEP     (STEP),
                .CW       (CW)
            ) u_obj (
                .clk          (clk),
                .reset        (reset),
                .i_frame_tick (frame_tick),
                .i_cmd_en     (w_accept && (cmd_id == C_IDW'(gi))),
                .i_cmd_op     (cmd_op),
                .i_cmd_count  (cmd_count),
                .o_x          (obj_x[gi*CW +: CW]),
                .o_y          (obj_y[gi*CW +: CW]),
                .o_busy       (busy[gi]),
                .o_hit_edge   (hit_edge[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_object_mover.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_multi_object_mover                                            |
// | Directed scenarios plus randomized traffic against a model.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_multi_object_mover;

    localparam int N    = 4;
    localparam int CW   = 11;
    localparam int STEP = 5;
    localparam int MAXX = 640 - 32;
    localparam int MAXY = 480 - 24;
    localparam int CX   = 304;
    localparam int CY   = 228;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              frame_tick = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_id = '0;
    logic [2:0]        cmd_op = '0;
    logic [7:0]        cmd_count = '0;
    logic [N*CW-1:0]   obj_x, obj_y;
    logic [N-1:0]      busy, hit_edge;

    multi_object_mover dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_id     (cmd_id),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .busy       (busy),
        .hit_edge   (hit_edge)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer positions and remaining step counts.
    int       mx[N], my[N], mrem[N], mdir[N];
    logic [N-1:0] mhit;
    int       tests = 0;
    int       fails = 0;
    logic     ready_obs, ready_exp;

    function automatic int gx(input int i);
        return int'(obj_x[i*CW +: CW]);
    endfunction

    function automatic int gy(input int i);
        return int'(obj_y[i*CW +: CW]);
    endfunction

    function automatic logic model_ready();
        return (cmd_op == 3'd0) || (cmd_op == 3'd5) || (int'(cmd_id) >= N) || (mrem[cmd_id] == 0);
    endfunction

    task automatic model_edge();
        logic acc;
        int   pos, lim, np;
        acc = cmd_valid && model_ready();
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                mx[i] = CX; my[i] = CY; mrem[i] = 0;
            end
            mhit = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                mhit[i] = 1'b0;
                if (acc && int'(cmd_id) == i) begin
                    if (cmd_op == 3'd0) mrem[i] = 0;
                    else if (cmd_op == 3'd5) begin
                        mx[i] = CX; my[i] = CY; mrem[i] = 0;
                    end else if (cmd_op <= 3'd4 && cmd_count != 0) begin
                        mdir[i] = int'(cmd_op);
                        mrem[i] = int'(cmd_count);
                    end
                end else if (frame_tick && mrem[i] > 0) begin
                    pos = (mdir[i] <= 2) ? mx[i] : my[i];
                    lim = (mdir[i] <= 2) ? MAXX : MAXY;
                    np  = (mdir[i] == 1 || mdir[i] == 3) ? pos - STEP : pos + STEP;
                    mrem[i] = mrem[i] - 1;
`ifdef OBJ_WRAP_EN
                    if (np < 0) begin np = np + lim + 1; mhit[i] = 1'b1; end
                    else if (np > lim) begin np = np - lim - 1; mhit[i] = 1'b1; end
`else
                    if (np < 0) begin np = 0; mhit[i] = 1'b1; mrem[i] = 0; end
                    else if (np > lim) begin np = lim; mhit[i] = 1'b1; mrem[i] = 0; end
`endif
                    if (mdir[i] <= 2) mx[i] = np;
                    else              my[i] = np;
                end
            end
        end
    endtask

    // Applies one cycle of inputs, captures cmd_ready, advances the model at the edge.
    task automatic drive(input logic rst_n, input logic tk, input logic v,
                         input logic [1:0] id, input logic [2:0] op, input logic [7:0] cnt);
        reset = rst_n; frame_tick = tk; cmd_valid = v;
        cmd_id = id; cmd_op = op; cmd_count = cnt;
        #2;
        ready_obs = cmd_ready;
        ready_exp = model_ready();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        drive(1'b0, 1'b1, 1'b1, 2'd0, 3'd2, 8'd9);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        for (int i = 0; i < N; i++) begin
            tests++;
            if (gx(i) !== CX || gy(i) !== CY) begin
                fails++;
                $display("FAIL reset_pos[%0d]: got (%0d,%0d) expected (304,228)", i, gx(i), gy(i));
            end
        end
        tests++;
        if (busy !== 4'b0000 || hit_edge !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: busy=%b hit=%b expected 0000/0000", busy, hit_edge);
        end
    endtask

    task automatic test_right();
        drive(1'b1, 1'b0, 1'b1, 2'd0, 3'd2, 8'd3);
        tests++;
        if (busy[0] !== 1'b1 || gx(0) !== CX) begin
            fails++;
            $display("FAIL right_accept: busy0=%b x=%0d expected 1/304", busy[0], gx(0));
        end
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
            tests++;
            if (gx(0) !== CX + 5*k || busy[0] !== (k < 3)) begin
                fails++;
                $display("FAIL right_step%0d: x=%0d busy0=%b expected %0d/%b", k, gx(0), busy[0], CX + 5*k, (k < 3));
            end
        end
    endtask

    task automatic test_left_edge();
`ifdef OBJ_WRAP_EN
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 8'd60);
        for (int k = 0; k < 60; k++) drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
        tests++;
        if (gx(1) !== 4 || busy[1] !== 1'b0) begin
            fails++;
            $display("FAIL wrap_pre: x=%0d busy1=%b expected 4/0", gx(1), busy[1]);
        end
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 8'd2);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
        tests++;
        if (gx(1) !== 608 || hit_edge[1] !== 1'b1 || busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL wrap_step1: x=%0d hit=%b busy=%b expected 608/1/1", gx(1), hit_edge[1], busy[1]);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
        tests++;
        if (gx(1) !== 603 || hit_edge[1] !== 1'b0 || busy[1] !== 1'b0) begin
            fails++;
            $display("FAIL wrap_step2: x=%0d hit=%b busy=%b expected 603/0/0", gx(1), hit_edge[1], busy[1]);
        end
`else
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 8'd100);
        for (int k = 0; k < 60; k++) drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
        tests++;
        if (gx(1) !== 4 || busy[1] !== 1'b1 || hit_edge[1] !== 1'b0) begin
            fails++;
            $display("FAIL clamp_60: x=%0d busy=%b hit=%b expected 4/1/0", gx(1), busy[1], hit_edge[1]);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
        tests++;
        if (gx(1) !== 0 || hit_edge[1] !== 1'b1 || busy[1] !== 1'b0) begin
            fails++;
            $display("FAIL clamp_61: x=%0d hit=%b busy=%b expected 0/1/0", gx(1), hit_edge[1], busy[1]);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
        tests++;
        if (gx(1) !== 0 || hit_edge[1] !== 1'b0) begin
            fails++;
            $display("FAIL clamp_idle: x=%0d hit=%b expected 0/0", gx(1), hit_edge[1]);
        end
`endif
    endtask

    task automatic test_busy_center();
        drive(1'b1, 1'b0, 1'b1, 2'd2, 3'd2, 8'd10);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
        drive(1'b1, 1'b0, 1'b1, 2'd2, 3'd2, 8'd4);
        tests++;
        if (ready_obs !== 1'b0 || gx(2) !== CX + 5 || busy[2] !== 1'b1) begin
            fails++;
            $display("FAIL busy_reject: ready=%b x=%0d busy=%b expected 0/309/1", ready_obs, gx(2), busy[2]);
        end
        drive(1'b1, 1'b0, 1'b1, 2'd2, 3'd5, 8'd0);
        tests++;
        if (ready_obs !== 1'b1 || gx(2) !== CX || gy(2) !== CY || busy[2] !== 1'b0) begin
            fails++;
            $display("FAIL center_moving: ready=%b pos=(%0d,%0d) busy=%b expected 1/(304,228)/0",
                     ready_obs, gx(2), gy(2), busy[2]);
        end
    endtask

    task automatic test_cmd_tick_reset();
        drive(1'b1, 1'b1, 1'b1, 2'd3, 3'd4, 8'd5);
        tests++;
        if (gy(3) !== CY || busy[3] !== 1'b1) begin
            fails++;
            $display("FAIL cmd_tick_same: y=%0d busy=%b expected 228/1", gy(3), busy[3]);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
        tests++;
        if (gy(3) !== CY + 5) begin
            fails++;
            $display("FAIL cmd_tick_next: y=%0d expected 233", gy(3));
        end
        drive(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0);
        tests++;
        if (gy(3) !== CY || gx(0) !== CX || busy !== 4'b0000) begin
            fails++;
            $display("FAIL reset_mid: y3=%0d x0=%0d busy=%b expected 228/304/0000", gy(3), gx(0), busy);
        end
        drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
    endtask

    task automatic test_random();
        logic rst_n, tk, v;
        logic [7:0] cnt;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0);
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            tk    = ($urandom_range(0, 2) == 0);
            v     = ($urandom_range(0, 3) == 0);
            cnt   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            drive(rst_n, tk, v, 2'($urandom), 3'($urandom), cnt);
            tests++;
            if (ready_obs !== ready_exp) begin
                fails++;
                $display("FAIL rnd_ready c=%0d: got %b expected %b", c, ready_obs, ready_exp);
            end
            for (int i = 0; i < N; i++) begin
                tests++;
                if (gx(i) !== mx[i] || gy(i) !== my[i] || busy[i] !== (mrem[i] > 0) || hit_edge[i] !== mhit[i]) begin
                    fails++;
                    $display("FAIL rnd_obj%0d c=%0d: got (%0d,%0d,b%b,h%b) expected (%0d,%0d,b%b,h%b)",
                             i, c, gx(i), gy(i), busy[i], hit_edge[i], mx[i], my[i], (mrem[i] > 0), mhit[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mx[i] = CX; my[i] = CY; mrem[i] = 0; mdir[i] = 1;
        end
        mhit = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_right();
        test_left_edge();
        test_busy_center();
        test_cmd_tick_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_object_mover.md
MULTI_OBJECT_MOVER -- requirements
Module: multi_object_mover

Interface
REQ-001 Parameter N_OBJ, default 4: number of independently tracked objects.
REQ-002 Parameter SCREEN_W / SCREEN_H, default 640 / 480: active screen size in pixels.
REQ-003 Parameter OBJ_W / OBJ_H, default 32 / 24: object size, common to all objects.
REQ-004 Parameter STEP, default 5: pixels moved per frame tick.
REQ-005 Parameter CW, default 11: coordinate width; all coordinates are unsigned.
REQ-006 clk  in  1  sole clock; every register updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 frame_tick  in  1  one-cycle pulse per frame; each pulse advances motion.
REQ-009 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a command is accepted when both are high in one cycle.
REQ-010 cmd_id  in  clog2(N_OBJ)  target object index; values >= N_OBJ are accepted and ignored.
REQ-011 cmd_op  in  3  opcode: 0 STOP, 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN, 5 CENTER, 6-7 ignored (accepted, no effect).
REQ-012 cmd_count  in  8  number of steps for opcodes 1-4.
REQ-013 obj_x / obj_y  out  N_OBJ*CW  packed top-left coordinates; object i occupies bits [i*CW +: CW].
REQ-014 busy  out  N_OBJ  per-object "motion in progress" flag.
REQ-015 hit_edge  out  N_OBJ  one-cycle pulse when object i reaches a bound or wraps.

Function
REQ-016 Each object has a two-state FSM, IDLE and MOVING, with a latched direction and a remaining-step counter (8 bits).
REQ-017 cmd_ready is combinational: high if cmd_op is 0 or 5, or cmd_id >= N_OBJ, or busy[cmd_id] is 0.
REQ-018 Accepted LEFT/RIGHT/UP/DOWN with count > 0 loads the direction and counter; the object enters MOVING and busy rises on the next cycle.
REQ-019 Accepted LEFT/RIGHT/UP/DOWN with count 0 is a no-op.
REQ-020 STOP forces the object to IDLE on the next cycle; the position is held.
REQ-021 CENTER sets x = (SCREEN_W-OBJ_W)/2 and y = (SCREEN_H-OBJ_H)/2, forces IDLE, and is accepted even while MOVING.
REQ-022 On frame_tick, every MOVING object moves STEP pixels in its direction and decrements its counter; it returns to IDLE when the counter reaches 0.
REQ-023 A command accepted in the same cycle as frame_tick takes precedence for that object; its first step occurs on the next frame_tick.
REQ-024 Clamp mode: x stays in [0, SCREEN_W-OBJ_W] and y in [0, SCREEN_H-OBJ_H]. A step that would exceed a bound sets the coordinate to that bound, pulses hit_edge[i], and returns the object to IDLE.
REQ-025 A step landing exactly on a bound does not count as a hit.
REQ-026 Intermediate arithmetic uses CW+1 bits signed; no overflow reaches the outputs.
REQ-027 IDLE objects ignore frame_tick, and hit_edge stays 0 for them.

Reset
REQ-028 While reset is 0 at a clock edge: every object goes to the CENTER position (304, 228 at default parameters).
REQ-029 Also while reset is 0: busy = 0, hit_edge = 0, counters = 0, and commands are ignored.
REQ-030 Reset during MOVING aborts the motion; the reset values appear on the first edge with reset low.

Configuration
REQ-031 Macro OBJ_WRAP_EN defined: coordinates wrap modulo (SCREEN_W-OBJ_W+1) and (SCREEN_H-OBJ_H+1) instead of clamping.
REQ-032 With OBJ_WRAP_EN defined, a wrap pulses hit_edge[i] and motion continues (busy stays high).
REQ-033 OBJ_WRAP_EN undefined: clamp behaviour per REQ-024.

Structure
REQ-034 Shared package mover_pkg holds the opcode enum and the default screen and object constants.
REQ-035 One sub-module, object_motion, holds a single object's FSM, counter and position arithmetic; the top instantiates N_OBJ copies and decodes cmd_id.

Verification
REQ-036 Reset low, then high -> all obj_x = 304, obj_y = 228; busy = 0.
REQ-037 Obj0 RIGHT count 3, then 3 frame_ticks -> x 309, 314, 319; busy[0] falls after the third tick.
REQ-038 Obj1 LEFT count 100 from x = 304 -> x = 4 after 60 ticks; tick 61 gives x = 0, hit_edge[1] pulses, busy[1] = 0.
REQ-039 OBJ_WRAP_EN, obj1 at x = 4, LEFT count 2 -> x 608, then 603; hit_edge[1] pulses once; busy falls after step 2.
REQ-040 Obj2 MOVING -> RIGHT to obj2 has cmd_ready = 0; CENTER to obj2 is accepted and sets x = 304, y = 228, busy = 0.
REQ-041 Command and frame_tick in the same cycle, then reset low mid-motion -> no step on that tick; reset restores the center position and clears busy.
